// File: rtl/i2c_slave_regfile.sv
// I2C responder (7-bit address SLAVE_ADDR) fronting a DEPTH x 8 register file with auto-increment.
// Latency: a pin change is seen 3 clk_12m cycles later; host_rdata is combinational and shows a write the cycle after wr_strobe.
// Backpressure: none - SCL is never stretched and the local write port is a fire-and-forget pulse.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h40,
  parameter int         DEPTH      = 16,
  parameter int         AW         = 4
) (
  input  logic          clk_12m,
  input  logic          rst_n,
  input  logic          scl,
  inout  wire           sda,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic [7:0]    state_debug
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DEV_ADDR  = 4'd1,
    DEV_ACK   = 4'd2,
    REG_ADDR  = 4'd3,
    REG_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  // Synchronizer and edge-detect history; idle bus level is high so reset to 1
  logic scl_s1, scl_s2, scl_prev;
  logic sda_s1, sda_s2, sda_prev;

  logic scl_rise, scl_fall, start_evt, stop_evt;

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic [7:0]      rx_sr, rx_n;
  logic [7:0]      tx_sr, tx_n;
  logic [AW-1:0]   ptr, ptr_n;
  logic            rw, rw_n;
  logic            sda_oe, oe_n;
  logic            busy_n;
  logic            wstb_n;
  logic [AW-1:0]   waddr_n;
  logic [7:0]      wdata_n;

  logic [7:0]      regfile [DEPTH];

  // Open-drain output: pull low or release
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign host_rdata  = regfile[host_addr];
  assign state_debug = {4'h0, state};

  // Two-stage synchronizers plus one history stage for edge detection
  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_prev <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_s1   <= scl;
      scl_s2   <= scl_s1;
      scl_prev <= scl_s2;
      sda_s1   <= sda;
      sda_s2   <= sda_s1;
      sda_prev <= sda_s2;
    end
  end

  assign scl_rise  =  scl_s2 & ~scl_prev;
  assign scl_fall  = ~scl_s2 &  scl_prev;
  assign start_evt =  scl_s2 &  scl_prev &  sda_prev & ~sda_s2;
  assign stop_evt  =  scl_s2 &  scl_prev & ~sda_prev &  sda_s2;

  // State and datapath registers
  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rx_sr     <= 8'h00;
      tx_sr     <= 8'h00;
      ptr       <= '0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rx_sr     <= rx_n;
      tx_sr     <= tx_n;
      ptr       <= ptr_n;
      rw        <= rw_n;
      sda_oe    <= oe_n;
      busy      <= busy_n;
      wr_strobe <= wstb_n;
      wr_addr   <= waddr_n;
      wr_data   <= wdata_n;
    end
  end

  // Regfile commits from the registered strobe, so local reads see it one cycle later
  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regfile[i] <= 8'h00;
    end else if (wr_strobe) begin
      regfile[wr_addr] <= wr_data;
    end
  end

  // Next-state logic: bus conditions first, then rising-edge sampling, then falling-edge actions
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rx_n    = rx_sr;
    tx_n    = tx_sr;
    ptr_n   = ptr;
    rw_n    = rw;
    oe_n    = sda_oe;
    busy_n  = busy;
    wstb_n  = 1'b0;
    waddr_n = wr_addr;
    wdata_n = wr_data;

    if (start_evt) begin
      state_n = DEV_ADDR;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
    end else if (stop_evt) begin
      state_n = IDLE;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (scl_rise) begin
      // Every active state samples the line; ACK states use rx_n[0] as the master's ACK bit
      if (state != IDLE && state != WAIT_STOP) begin
        rx_n = {rx_sr[6:0], sda_s2};
        if (cnt != 4'd8) cnt_n = cnt + 4'd1;
      end
    end else if (scl_fall) begin
      unique case (state)
        DEV_ADDR: begin
          if (cnt == 4'd8) begin
            // General-call (0x00) is never matched
            if (rx_sr[7:1] == SLAVE_ADDR && rx_sr[7:1] != 7'h00) begin
              state_n = DEV_ACK;
              rw_n    = rx_sr[0];
              oe_n    = 1'b1;
              busy_n  = 1'b1;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        DEV_ACK: begin
          cnt_n = 4'd0;
          if (rw) begin
            state_n = RDATA;
            tx_n    = regfile[ptr];
            oe_n    = ~regfile[ptr][7];
          end else begin
            state_n = REG_ADDR;
            oe_n    = 1'b0;
          end
        end
        REG_ADDR: begin
          if (cnt == 4'd8) begin
            ptr_n   = rx_sr[AW-1:0];
            oe_n    = 1'b1;
            state_n = REG_ACK;
          end
        end
        REG_ACK, WDATA_ACK: begin
          cnt_n   = 4'd0;
          oe_n    = 1'b0;
          state_n = WDATA;
        end
        WDATA: begin
          if (cnt == 4'd8) begin
            wstb_n  = 1'b1;
            waddr_n = ptr;
            wdata_n = rx_sr;
            ptr_n   = ptr + AW'(1);
            oe_n    = 1'b1;
            state_n = WDATA_ACK;
          end
        end
        RDATA: begin
          if (cnt == 4'd8) begin
            oe_n    = 1'b0;
            ptr_n   = ptr + AW'(1);
            state_n = RDATA_ACK;
          end else begin
            tx_n = {tx_sr[6:0], 1'b0};
            oe_n = ~tx_sr[6];
          end
        end
        RDATA_ACK: begin
          if (rx_sr[0] == 1'b0) begin
            cnt_n   = 4'd0;
            tx_n    = regfile[ptr];
            oe_n    = ~regfile[ptr][7];
            state_n = RDATA;
          end else begin
            oe_n    = 1'b0;
            state_n = WAIT_STOP;
          end
        end
        default: begin
          oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- I2C responder (slave) holding a small byte-wide register file.
- It is the other end of our I2C master sequencer. On the board it stands in for a sensor, and in simulation it is the bus target for master regression.
- It decodes START, STOP and repeated START; matches a 7-bit device address; and supports register-pointer writes, auto-incrementing data writes and auto-incrementing reads.
- It drives SDA open-drain (low or release only) and samples SCL/SDA synchronously on the system clock.

Parameters:
- SLAVE_ADDR, 7'h40, 7-bit device address this block answers to.
- DEPTH, 16, number of 8-bit registers; must be a power of 2, range 2..256.
- AW, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk_12m, input, 1, system clock, 12 MHz.
- rst_n, input, 1, asynchronous active-low reset.
- scl, input, 1, I2C clock from the master (the slave never stretches).
- sda, inout, 1, I2C data. Driven 1'b0 when the internal output-enable is set, otherwise 1'bz.
- host_addr, input, AW, local read-port address.
- host_rdata, output, 8, combinational regfile[host_addr].
- wr_strobe, output, 1, one-cycle pulse when a received data byte is committed.
- wr_addr, output, AW, register written; valid with wr_strobe.
- wr_data, output, 8, byte written; valid with wr_strobe.
- busy, output, 1, high from an addressed START (address match) until STOP.
- state_debug, output, 8, current state encoding, zero-extended.

Behaviour:
- Reset (async, rst_n low):
  - All regfile entries are 8'h00 and the pointer is 0.
  - sda is released; wr_strobe=0, wr_addr=0, wr_data=0, busy=0, state_debug=0 (IDLE).
  - Reset mid-transfer releases sda immediately, without waiting for a clock edge.
- Input conditioning:
  - scl and sda each pass through a 2-FF synchronizer, then a previous-value register for edge detection.
  - A pin change becomes visible as an event 3 clk_12m cycles later.
- Bus events, derived from the synchronized signals:
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - Rising and falling scl edges are detected separately.
  - START/STOP take priority over bit processing in the same cycle.
- Bit timing:
  - Input bits are sampled on the scl rising edge.
  - sda output changes only in the cycle after an scl falling edge. The same applies to ACK assertion, ACK release and read-data bits.
- States:
  - IDLE
  - DEV_ADDR: 8 bits, MSB first.
  - DEV_ACK
  - REG_ADDR
  - REG_ACK
  - WDATA
  - WDATA_ACK
  - RDATA
  - RDATA_ACK: sample the master's ACK/NACK.
  - WAIT_STOP
- START, from any state (repeated START included): go to DEV_ADDR and clear the bit counter.
- STOP, from any state: go to IDLE, release sda, busy=0.
- DEV_ADDR, after 8 bits:
  - Address mismatch: go to WAIT_STOP without driving sda (NACK by release).
  - Match: go to DEV_ACK and pull sda low for one SCL period; busy=1.
  - After the ACK, R/W=0 goes to REG_ADDR; R/W=1 goes to RDATA.
- REG_ADDR:
  - The received byte's low AW bits load the pointer; the upper bits are ignored.
  - Always ACK, then go to WDATA.
- WDATA, after 8 bits:
  - Write regfile[pointer], pulse wr_strobe with wr_addr=pointer and wr_data=byte, then ACK.
  - Increment the pointer modulo DEPTH: DEPTH-1 wraps to 0.
  - Return to WDATA for further bytes.
- RDATA:
  - Shift register loads regfile[pointer] on the scl falling edge ending the preceding ACK.
  - Drive MSB first: bit=0 pulls sda low, bit=1 releases it.
  - After 8 bits, release sda, go to RDATA_ACK, and increment the pointer modulo DEPTH.
- RDATA_ACK:
  - Master ACK (sda=0 sampled): go to RDATA with the next byte.
  - Master NACK: go to WAIT_STOP with sda released.
- WAIT_STOP: ignore bits; leave only on STOP or START.
- Simultaneous local and bus activity: host_rdata reflects a write from the cycle after wr_strobe.
- General-call address (0x00) is not supported and is NACKed.
- No clock stretching.

Test Plan:
- Write, single byte: START, 0x80, 0x03, 0xA5, STOP.
  - All three bytes ACKed; one wr_strobe with wr_addr=3, wr_data=8'hA5.
  - host_addr=3 then gives host_rdata=8'hA5; busy returns to 0 after STOP.
- Burst write with wrap: START, 0x80, 0x0E, then 0x11, 0x22, 0x33, STOP.
  - Regs 14, 15 and 0 hold 8'h11, 8'h22, 8'h33; three wr_strobe pulses with addresses 14, 15, 0.
- Read with repeated START: preload regs 5=8'h3C and 6=8'hC3. Then START, 0x80, 0x05, Sr, 0x81, master ACK, master NACK, STOP.
  - Bytes returned are 8'h3C then 8'hC3; sda is released during the master NACK bit.
- Address mismatch: START, 0x90, 0x05, STOP.
  - sda is never driven low; no wr_strobe; busy stays 0; state_debug returns to IDLE.
- Abort with STOP: STOP after 4 bits of a WDATA byte.
  - No register changes and no wr_strobe; state goes to IDLE.
  - The next valid write transaction still succeeds.
- Reset mid-read: assert rst_n low while the slave is driving 0 on sda in RDATA.
  - sda goes to z asynchronously; all regs read 8'h00 after reset; state is IDLE.
